// File: rtl/vlsu_issue_queue_pkg.sv
// Shared types for the VLSU issue queue: memory opcodes, instruction field layout, FSM states.
// Helper functions keep opcode and register-field decoding in one place.
package vlsu_issue_queue_pkg;

   typedef enum logic [6:0] {
      OPC_VLOAD  = 7'b0000111,
      OPC_VSTORE = 7'b0100111
   } opcode_e;

   // vd for loads, vs3 for stores, both live in [11:7]
   typedef struct packed {
      logic [19:0] upper;
      logic [4:0]  vreg;
      logic [6:0]  opcode;
   } mem_instr_t;

   typedef enum logic [1:0] {
      IQ_IDLE,
      IQ_ISSUE,
      IQ_WAIT
   } iq_fsm_t;

   function automatic logic is_mem_opcode(input logic [6:0] opc);
      return (opc == 7'(OPC_VLOAD)) || (opc == 7'(OPC_VSTORE));
   endfunction

   function automatic logic [4:0] get_vreg(input logic [31:0] instr);
      mem_instr_t w_f;
      w_f = mem_instr_t'(instr);
      return w_f.vreg;
   endfunction

endpackage

// File: rtl/vlsu_issue_queue.sv
// Buffers vector load/store instructions and issues them one at a time to the VLSU; push to request is 2 cycles, completion to next request 1 cycle.
// Backpressure: enq_ready_o drops only when all entries are queued; in-flight operand registers hold until the VLSU completion pulse.
module vlsu_issue_queue
   import vlsu_issue_queue_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   localparam int CNT_B     = $clog2(DEPTH) + 1
) (
   input  logic                  clk_i,
   input  logic                  resetn_i,
   input  logic                  enq_valid_i,
   input  logic [DATA_WIDTH-1:0] enq_instr_i,
   input  logic [DATA_WIDTH-1:0] enq_rs1_i,
   input  logic [DATA_WIDTH-1:0] enq_rs2_i,
   output logic                  enq_ready_o,
   input  logic                  flush_i,
   output logic                  lsu_req_o,
   output logic [DATA_WIDTH-1:0] lsu_instr_o,
   output logic [DATA_WIDTH-1:0] lsu_rs1_o,
   output logic [DATA_WIDTH-1:0] lsu_rs2_o,
   input  logic                  lsu_ready_i,
   input  logic [4:0]            query_vreg_i,
   output logic                  query_hit_o,
   output logic [CNT_B-1:0]      count_o,
   output logic                  busy_o,
   output logic                  err_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] r_instr [DEPTH];
   logic [DATA_WIDTH-1:0] r_rs1   [DEPTH];
   logic [DATA_WIDTH-1:0] r_rs2   [DEPTH];
   logic [DEPTH-1:0]      r_vld;
   logic [PTR_W-1:0]      r_wptr;
   logic [PTR_W-1:0]      r_rptr;
   logic [CNT_B-1:0]      r_count;
   iq_fsm_t               r_state;
   logic                  r_req;
   logic                  r_err;
   logic                  r_if_vld;
   logic [DATA_WIDTH-1:0] r_lsu_instr;
   logic [DATA_WIDTH-1:0] r_lsu_rs1;
   logic [DATA_WIDTH-1:0] r_lsu_rs2;

   logic w_full;
   logic w_nonempty;
   logic w_opc_ok;
   logic w_enq_acc;
   logic w_push;
   logic w_pop;
   logic w_hit;

   assign w_full     = (r_count == CNT_B'(DEPTH));
   assign w_nonempty = (r_count != '0);
   assign w_opc_ok   = is_mem_opcode(enq_instr_i[6:0]);
   assign w_enq_acc  = enq_valid_i && !w_full;
   assign w_push     = w_enq_acc && w_opc_ok && !flush_i;
   // A pop reads the pre-flush head, so flush does not gate it
   assign w_pop      = w_nonempty &&
                       ((r_state == IQ_IDLE) || ((r_state == IQ_WAIT) && lsu_ready_i));

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_instr[r_wptr] <= enq_instr_i;
         r_rs1[r_wptr]   <= enq_rs1_i;
         r_rs2[r_wptr]   <= enq_rs2_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         r_vld       <= '0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_state     <= IQ_IDLE;
         r_req       <= 1'b0;
         r_err       <= 1'b0;
         r_if_vld    <= 1'b0;
         r_lsu_instr <= '0;
         r_lsu_rs1   <= '0;
         r_lsu_rs2   <= '0;
      end else begin
         r_err <= w_enq_acc && !w_opc_ok;
         r_req <= 1'b0;

         if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_vld   <= '0;
         end else begin
            if (w_push) begin
               r_wptr        <= r_wptr + PTR_W'(1);
               r_vld[r_wptr] <= 1'b1;
            end
            if (w_pop) begin
               r_rptr        <= r_rptr + PTR_W'(1);
               r_vld[r_rptr] <= 1'b0;
            end
            r_count <= r_count + CNT_B'(w_push) - CNT_B'(w_pop);
         end

         if (w_pop) begin
            r_lsu_instr <= r_instr[r_rptr];
            r_lsu_rs1   <= r_rs1[r_rptr];
            r_lsu_rs2   <= r_rs2[r_rptr];
            r_if_vld    <= 1'b1;
         end

         case (r_state)
            IQ_IDLE: begin
               if (w_pop) begin
                  r_state <= IQ_ISSUE;
                  r_req   <= 1'b1;
               end
            end
            IQ_ISSUE: r_state <= IQ_WAIT;
            IQ_WAIT: begin
               if (lsu_ready_i) begin
                  if (w_pop) begin
                     r_state <= IQ_ISSUE;
                     r_req   <= 1'b1;
                  end else begin
                     r_state  <= IQ_IDLE;
                     r_if_vld <= 1'b0;
                  end
               end
            end
            default: r_state <= IQ_IDLE;
         endcase
      end
   end

   always_comb begin
      w_hit = r_if_vld && (get_vreg(r_lsu_instr[31:0]) == query_vreg_i);
      for (int i = 0; i < DEPTH; i++) begin
         if (r_vld[i] && (get_vreg(r_instr[i][31:0]) == query_vreg_i)) begin
            w_hit = 1'b1;
         end
      end
   end

   assign enq_ready_o = !w_full;
   assign lsu_req_o   = r_req;
   assign lsu_instr_o = r_lsu_instr;
   assign lsu_rs1_o   = r_lsu_rs1;
   assign lsu_rs2_o   = r_lsu_rs2;
   assign query_hit_o = w_hit;
   assign count_o     = r_count;
   assign busy_o      = r_if_vld || w_nonempty;
   assign err_o       = r_err;

endmodule
